// File: rtl/posit_pkg.sv
// Shared posit constants and the S2->S3 stage payload for the posit encoder.
// The flag fields exist only when POSIT_ENC_FLAGS_EN is defined.
package posit_pkg;

    localparam int MAX_N = 64;

    // Magnitude is sized for the widest supported posit; users take the low N-1 bits.
    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             nar;
        logic             zero;
`ifdef POSIT_ENC_FLAGS_EN
        logic             clamp;
        logic             inexact;
`endif
        logic [MAX_N-2:0] mag;
    } stage_t;

    function automatic logic [MAX_N-1:0] posit_nar(input int n);
        logic [MAX_N-1:0] w;
        w        = '0;
        w[n-1]   = 1'b1;
        return w;
    endfunction

    function automatic logic [MAX_N-1:0] posit_zero(input int n);
        logic [MAX_N-1:0] w;
        w        = '0;
        w[n-1]   = 1'b0;
        return w;
    endfunction

    function automatic logic [MAX_N-1:0] posit_maxpos_mag(input int n);
        return posit_nar(n) - 1;
    endfunction

    function automatic logic [MAX_N-1:0] posit_minpos_mag(input int n);
        return MAX_N'(n > 1);
    endfunction

endpackage

// File: rtl/posit_rne_round.sv
// Round-to-nearest-even on an assembled posit magnitude, with maxpos/minpos saturation.
// Combinational; the inexact output is only consumed when POSIT_ENC_FLAGS_EN is defined.
module posit_rne_round
    import posit_pkg::*;
#(
    parameter int W = 31
) (
    input  logic [W-1:0] mag,
    input  logic         guard,
    input  logic         sticky,
    input  logic         clamp_max,
    input  logic         clamp_min,
    output logic [W-1:0] rounded,
    output logic         inexact
);

    localparam logic [MAX_N-1:0] MAXPOS_W = posit_maxpos_mag(W + 1);
    localparam logic [MAX_N-1:0] MINPOS_W = posit_minpos_mag(W + 1);

    logic       inc;
    logic [W:0] sum;

    always_comb begin
        inc     = guard & (sticky | mag[0]);
        sum     = {1'b0, mag} + {{W{1'b0}}, inc};
        rounded = sum[W-1:0];
        // A carry out would spill into the sign bit (NaR); saturate instead.
        if (clamp_max || sum[W]) begin
            rounded = MAXPOS_W[W-1:0];
        end else if (clamp_min || sum[W-1:0] == '0) begin
            rounded = MINPOS_W[W-1:0];
        end
        inexact = guard | sticky | clamp_max | clamp_min;
    end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: S1 regime decode/clamp, S2 assembly and RNE, S3 negate/output.
// Define POSIT_ENC_FLAGS_EN to add the out_inexact/out_clamp ports and their pipeline.
module posit_encode_pipe
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sign,
    input  logic [ES+RS:0] in_le,
    input  logic [2*N-1:0] in_mant,
    input  logic           in_inf,
    input  logic           in_zero,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_posit
`ifdef POSIT_ENC_FLAGS_EN
    ,
    output logic           out_inexact,
    output logic           out_clamp
`endif
);

    localparam int MW = N - 1;
    localparam int FW = 2 * N - 1;
    localparam int KW = RS + 1;
    localparam int WW = ES + 3 * N + 1;

    localparam logic [MAX_N-1:0] NAR_W  = posit_nar(N);
    localparam logic [MAX_N-1:0] ZERO_W = posit_zero(N);

    typedef struct packed {
        logic          valid;
        logic          sign;
        logic          nar;
        logic          zero;
        logic          cmax;
        logic          cmin;
        logic          r0;
        logic [RS-1:0] sh;
        logic [ES-1:0] e;
        logic [FW-1:0] frac;
    } s1_t;

    s1_t    s1_d, s1_q;
    stage_t s2_d, s2_q;
    logic   stall;

    // Handshake: a beat moves on valid & ready; one global stall freezes every stage.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic signed [KW-1:0] k;
    int                   k_int;

    assign k = in_le[ES+RS:ES];

    always_comb begin
        k_int      = int'(k);
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.sign  = in_sign;
        s1_d.nar   = in_inf;
        s1_d.zero  = in_zero;
        s1_d.cmax  = k_int > N - 2;
        s1_d.cmin  = k_int < -(N - 2);
        s1_d.r0    = ~k[KW-1];
        // Run length minus one: k for positive regimes, -k-1 for negative ones.
        s1_d.sh    = k[KW-1] ? ~k[RS-1:0] : k[RS-1:0];
        s1_d.e     = in_le[ES-1:0];
        s1_d.frac  = in_mant[FW-1:0];
    end

    logic [WW-1:0] str, shifted;
    logic [MW-1:0] asm_mag, rnd_mag;
    logic          guard, sticky, rnd_inexact;

    // {r0, ~r0} shifted arithmetically grows the regime run; N zero bits of
    // padding keep every shifted-out bit visible to sticky.
    always_comb begin
        str     = {s1_q.r0, ~s1_q.r0, s1_q.e, s1_q.frac, {N{1'b0}}};
        shifted = $signed(str) >>> s1_q.sh;
        asm_mag = shifted[WW-1 -: MW];
        guard   = shifted[WW-1-MW];
        sticky  = |shifted[WW-2-MW:0];
    end

    posit_rne_round #(
        .W(MW)
    ) u_rnd (
        .mag      (asm_mag),
        .guard    (guard),
        .sticky   (sticky),
        .clamp_max(s1_q.cmax),
        .clamp_min(s1_q.cmin),
        .rounded  (rnd_mag),
        .inexact  (rnd_inexact)
    );

    always_comb begin
        s2_d             = '0;
        s2_d.valid       = s1_q.valid;
        s2_d.sign        = s1_q.sign;
        s2_d.nar         = s1_q.nar;
        s2_d.zero        = s1_q.zero;
        s2_d.mag[MW-1:0] = rnd_mag;
`ifdef POSIT_ENC_FLAGS_EN
        s2_d.clamp       = (s1_q.cmax | s1_q.cmin) & ~(s1_q.nar | s1_q.zero);
        s2_d.inexact     = rnd_inexact & ~(s1_q.nar | s1_q.zero);
`endif
    end

    logic [N-1:0] mag_word, word;

    always_comb begin
        mag_word = {1'b0, s2_q.mag[MW-1:0]};
        if (s2_q.nar) begin
            word = NAR_W[N-1:0];
        end else if (s2_q.zero) begin
            word = ZERO_W[N-1:0];
        end else if (s2_q.sign) begin
            word = -mag_word;
        end else begin
            word = mag_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.valid  <= 1'b0;
            s2_q.valid  <= 1'b0;
            out_valid   <= 1'b0;
            out_posit   <= '0;
`ifdef POSIT_ENC_FLAGS_EN
            out_inexact <= 1'b0;
            out_clamp   <= 1'b0;
`endif
        end else if (!stall) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_valid <= s2_q.valid;
            if (s2_q.valid) begin
                out_posit   <= word;
`ifdef POSIT_ENC_FLAGS_EN
                out_inexact <= s2_q.inexact;
                out_clamp   <= s2_q.clamp;
`endif
            end
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Self-checking bench for posit_encode_pipe at N=8, ES=2 against a bit-string posit model.
// Flag checks are compiled in when POSIT_ENC_FLAGS_EN is defined.
module tb_posit_encode_pipe;

    localparam int N  = 8;
    localparam int ES = 2;
    localparam int RS = 3;
    localparam int W  = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_sign = 1'b0;
    logic [ES+RS:0] in_le = '0;
    logic [2*N-1:0] in_mant = '0;
    logic           in_inf = 1'b0;
    logic           in_zero = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [N-1:0]   out_posit;
`ifdef POSIT_ENC_FLAGS_EN
    logic           out_inexact;
    logic           out_clamp;
`endif

    posit_encode_pipe #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_le    (in_le),
        .in_mant  (in_mant),
        .in_inf   (in_inf),
        .in_zero  (in_zero),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_posit(out_posit)
`ifdef POSIT_ENC_FLAGS_EN
        ,
        .out_inexact(out_inexact),
        .out_clamp  (out_clamp)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int             checks   = 0;
    int             failures = 0;
    int             pops     = 0;
    logic [W-1:0]   exp_q[$];
    logic [N-1:0]   held_posit;
    bit             held_valid = 0;
    bit             saw_ready_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=progress", name);
    endtask

    // Reference: write the posit bit string out, cut it at N-1 bits, round.
    function automatic logic [W-1:0] model(input bit s, input int le, input logic [15:0] mant,
                                           input bit inf, input bit zero);
        bit   bits[$];
        int   k, e, mag;
        bit   guard, sticky, clamp, inexact;
        logic [7:0] word;
        if (inf) return {2'b00, 8'h80};
        if (zero) return '0;
        e = ((le % 4) + 4) % 4;
        k = (le - e) / 4;
        clamp = 0;
        if (k > N - 2) begin
            mag = 127; clamp = 1; inexact = 1;
        end else if (k < -(N - 2)) begin
            mag = 1; clamp = 1; inexact = 1;
        end else begin
            if (k >= 0) begin
                for (int i = 0; i < k + 1; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[1]);
            bits.push_back(e[0]);
            for (int i = 14; i >= 0; i--) bits.push_back(mant[i]);
            mag = 0;
            for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(bits[i]);
            guard  = bits[N-1];
            sticky = 0;
            for (int i = N; i < bits.size(); i++) sticky |= bits[i];
            if (guard && (sticky || (mag % 2 == 1))) mag = mag + 1;
            if (mag > 127) mag = 127;
            if (mag == 0) mag = 1;
            inexact = guard | sticky;
        end
        word = s ? 8'((256 - mag) % 256) : 8'(mag);
        return {clamp, inexact, word};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input bit s, input int le, input logic [15:0] mant, input bit inf,
                        input bit zero);
        int waited;
        bit done;
        waited   = 0;
        done     = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_le    = 6'(le);
        in_mant  = mant;
        in_inf   = inf;
        in_zero  = zero;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(s, le, mant, inf, zero));
                done = 1;
            end else if (++waited > 200) begin
                timeout_fail("send_timeout");
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_inf   = 1'b0;
        in_zero  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) timeout_fail("drain_timeout");
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            held_valid = 0;
        end else if (out_valid) begin
            if (held_valid) check("stall_hold", 32'(out_posit), 32'(held_posit));
            if (!out_ready) begin
                check("in_ready_stall", 32'(in_ready), 32'd0);
                if (!in_ready) saw_ready_low = 1;
                held_valid = 1;
                held_posit = out_posit;
            end else begin
                held_valid = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_posit);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    check("posit", 32'(out_posit), 32'(e[7:0]));
`ifdef POSIT_ENC_FLAGS_EN
                    check("inexact", 32'(out_inexact), 32'(e[8]));
                    check("clamp", 32'(out_clamp), 32'(e[9]));
`endif
                end
            end
        end else begin
            held_valid = 0;
        end
    end

    // ---------------- directed vectors ----------------
    bit           t_s[14]    = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    int           t_le[14]   = '{1, 5, 0, 0, 31, -32, -32, 0, 0, 0, 24, -24, -21, 5};
    logic [15:0]  t_m[14]    = '{16'h8000, 16'hC000, 16'h8800, 16'h9800, 16'h8000, 16'h8000,
                                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                 16'h8000, 16'hC000};
    bit           t_inf[14]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    bit           t_zero[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic [W-1:0] t_exp[14]  = '{10'h048, 10'h066, 10'h140, 10'h142, 10'h37F, 10'h301,
                                 10'h3FF, 10'h080, 10'h000, 10'h080, 10'h07F, 10'h001,
                                 10'h102, 10'h09A};

    bit rand_done = 0;

    initial begin
        int cnt;
        int pops0;
        logic [15:0] m;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_posit", 32'(out_posit), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef POSIT_ENC_FLAGS_EN
        check("reset_inexact", 32'(out_inexact), 32'd0);
        check("reset_clamp", 32'(out_clamp), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Latency: value 1.0 positive then negative.
        check("model_pin_pos_one", 32'(model(0, 0, 16'h8000, 0, 0)), 32'h040);
        check("model_pin_neg_one", 32'(model(1, 0, 16'h8000, 0, 0)), 32'h0C0);
        send(0, 0, 16'h8000, 0, 0);
        idle();
        cnt = 1;
        while (cnt < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'd3);
        drain();
        send(1, 0, 16'h8000, 0, 0);
        idle();
        drain();

        // Directed: pin the model to hand-computed words, then run them back to back.
        for (int i = 0; i < 14; i++)
            check("model_pin", 32'(model(t_s[i], t_le[i], t_m[i], t_inf[i], t_zero[i])),
                  32'(t_exp[i]));
        for (int i = 0; i < 14; i++) send(t_s[i], t_le[i], t_m[i], t_inf[i], t_zero[i]);
        idle();
        drain();

        // Five-beat stream with out_ready low for cycles 4-7.
        pops0 = pops;
        saw_ready_low = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(0, 5 * i - 10, 16'h8000, 0, 0);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_in_ready_fell", 32'(saw_ready_low), 32'd1);
        check("stream_count", 32'(pops - pops0), 32'd5);

        // Reset mid-stream discards in-flight beats.
        send(0, 4, 16'hA000, 0, 0);
        send(1, 8, 16'hB000, 0, 0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_flush_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(0, -3, 16'hE000, 0, 0);
        idle();
        drain();

        // Randomized traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    m = {1'b1, 15'($urandom)};
                    if ($urandom_range(0, 3) == 0) m[7:0] = 8'h00;
                    send(1'($urandom), $urandom_range(0, 63) - 32, m,
                         $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
